// File: rtl/addsub_serial_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/sub unit.
package addsub_serial_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of digits processed per operation.
  function automatic int digit_cnt(input int w, input int d);
    return w / d;
  endfunction

  // Digit counter width; never below one bit so K=1 still has a counter.
  function automatic int cnt_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // Legal configuration: DIGIT divides WIDTH evenly.
  function automatic bit width_ok(input int w, input int d);
    return (d > 0) && (d <= w) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice; also exposes the carry into its MSB
// so the top can form signed overflow on the final digit.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] sum_d,
  output logic             cout,
  output logic             c_into_msb
);

  logic [DIGIT:0] c;

  // Bit-by-bit ripple through the slice.
  always_comb begin
    c     = '0;
    sum_d = '0;
    c[0]  = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum_d[i] = a_d[i] ^ b_d[i] ^ c[i];
      c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end
  end

  assign cout       = c[DIGIT];
  assign c_into_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: a +/- b with carry/borrow-in, DIGIT bits per
// clock, LSB digit first. Result and flags are held until the next completion.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int K  = digit_cnt(WIDTH, DIGIT);
  localparam int CW = cnt_width(K);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("addsub_serial: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] sum_d;
  logic             dig_cout;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_next;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d        (a_sh_q[DIGIT-1:0]),
    .b_d        (b_sh_q[DIGIT-1:0]),
    .cin        (c_q),
    .sum_d      (sum_d),
    .cout       (dig_cout),
    .c_into_msb (dig_cmsb)
  );

  // New digit enters the result shift register from the top.
  assign res_next = (res_sh_q >> DIGIT) | (WIDTH'(sum_d) << (WIDTH - DIGIT));

  // Next-state, datapath shifts and completion capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    c_d      = c_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = subtract ? ~b : b;
          c_d     = carry_in ^ subtract;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> DIGIT;
        b_sh_d   = b_sh_q >> DIGIT;
        c_d      = dig_cout;
        res_sh_d = res_next;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(K - 1)) begin
          result_d = res_next;
          cout_d   = dig_cout;
          ovf_d    = dig_cout ^ dig_cmsb;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      c_q      <= c_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial adder/subtractor: successor to the 4-bit structural add/sub.
- Computes a ± b with carry/borrow-in over WIDTH bits, DIGIT bits per clock, LSB digit first.
- Start/ready/done handshake; result held after completion.
- Sits as a shared arithmetic unit where area matters more than single-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH % DIGIT == 0 is required; K = WIDTH/DIGIT is the digit count.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; accepted only when ready=1
- subtract  input  1  0 = add, 1 = subtract
- a  input  WIDTH  operand A, sampled at acceptance
- b  input  WIDTH  operand B, sampled at acceptance
- carry_in  input  1  carry-in (add) / borrow-in (subtract), sampled at acceptance
- ready  output  1  block idle, can accept start
- done  output  1  one-cycle pulse, result valid
- result  output  WIDTH  sum/difference, held until next completion
- carry_out  output  1  carry out of MSB (subtract: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset, synchronous, rst_n=0 at edge:
  - state=IDLE, ready=1, done=0, result=0, carry_out=0, overflow=0.
  - Any in-flight operation is aborted with no done pulse.
- Arithmetic:
  - Effective operand is b_eff = subtract ? ~b : b.
  - Effective carry seed is c0 = carry_in XOR subtract.
  - Result = a + b_eff + c0 mod 2^WIDTH.
  - Add gives a+b+carry_in; subtract gives a-b-carry_in.
  - carry_out is the raw carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
- FSM states: IDLE and RUN.
- IDLE:
  - ready=1.
  - On start=1 at an edge: latch a, b_eff and c0 into shift registers, digit counter=0, go to RUN.
- RUN:
  - ready=0.
  - Each edge: add the low DIGIT bits of a and b_eff with the carry register; shift the sum digit into the result shift register from the top; update the carry register; increment the counter.
  - On the edge where counter==K-1: write result/carry_out/overflow output registers, pulse done=1 for the following cycle, return to IDLE.
- Latency:
  - Start sampled at edge E0; done high in the cycle after edge E0+K.
  - ready returns high in the same cycle as done.
- Back-to-back: start in the done cycle is accepted. The next result/flags overwrite outputs only at that operation's completion.
- start while ready=0 is ignored (not queued); operand changes during RUN have no effect.
- result, carry_out and overflow change only at a completion edge or reset, and are stable otherwise.
- K=1 (DIGIT=WIDTH): one RUN cycle, done in the cycle after E0+1.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE, RUN).
  - The K derivation and counter width, clog2(K) with a minimum of 1.
  - A WIDTH % DIGIT elaboration check.
- One sub-module, addsub_digit: combinational DIGIT-bit ripple slice.
  - Inputs: a_d, b_d, cin.
  - Outputs: sum_d, cout, c_into_msb (used for overflow on the last digit).
- Top level holds the FSM, counter, shift registers and output registers.

Test Plan (WIDTH=16, DIGIT=4, K=4 unless noted):
- Reset: assert rst_n=0 for 2 cycles mid-RUN → ready=1, done=0, result=0x0000, carry_out=0, overflow=0; no done pulse follows.
- Add: 0x0001+0x0001, carry_in=1, subtract=0 → done exactly in the cycle after E0+4; result=0x0003, carry_out=0, overflow=0.
- Add wrap and overflow:
  - 0xFFFF+0x0001, cin=0 → result=0x0000, carry_out=1, overflow=0.
  - 0x7FFF+0x0001, cin=0 → result=0x8000, carry_out=0, overflow=1.
- Subtract:
  - 0x0000-0x0001, cin=0 → result=0xFFFF, carry_out=0.
  - 0x0003-0x0001, cin=1 (borrow) → result=0x0001, carry_out=1.
  - 0x8000-0x0001, cin=0 → result=0x7FFF, overflow=1.
- Handshake:
  - start pulsed during RUN with other operands → ignored; original result delivered.
  - start asserted in the done cycle → accepted; second done exactly K+1 cycles later.
  - result unchanged between completions.
- Config WIDTH=8, DIGIT=8: 0x7F+0x01, cin=0 → result=0x80, overflow=1; done in the cycle after E0+1.
